// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. Holds the PC, drives the
// instruction-memory address and captures fetched words, honouring stall/kill from hazard logic.
module fetch_if_id_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_stall,
    input  logic            branch_kill,
    input  logic            jump_kill,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_misalign
);

    localparam logic [0:0]      ST_BOOT = 1'b0;
    localparam logic [0:0]      ST_RUN  = 1'b1;
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(32'd4);
    localparam logic [XLEN-1:0] PC_ZERO = {XLEN{1'b0}};

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            misalign_q, misalign_d;
    logic            redirect_s;
    logic [XLEN-1:0] redirect_target_s;

    // Redirect source: a resolved branch is older than a jump in ID/EX, so it wins.
    always_comb begin
        redirect_s        = 1'b0;
        redirect_target_s = PC_ZERO;
        if (branch_kill) begin
            redirect_s        = 1'b1;
            redirect_target_s = branch_target;
        end else if (jump_kill) begin
            redirect_s        = 1'b1;
            redirect_target_s = jump_target;
        end else begin
            redirect_s        = 1'b0;
            redirect_target_s = PC_ZERO;
        end
    end

    // Next-state logic: BOOT holds everything for one cycle, RUN applies kill > stall > advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        misalign_d    = misalign_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_s) begin
                    // Target is force-aligned; a misaligned request is only recorded.
                    pc_d          = {redirect_target_s[XLEN-1:2], 2'b00};
                    if_id_pc_d    = PC_ZERO;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    misalign_d    = misalign_q | (redirect_target_s[1:0] != 2'b00);
                end else if (!clk_stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d          = pc_q + PC_INC;
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= PC_ZERO;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_valid    = if_id_valid_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed bench for fetch_if_id_stage; imem returns addr ^ 0xDEAD0000 so fetched words are traceable.
module tb_fetch_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_stall;
    logic        branch_kill;
    logic        jump_kill;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    fetch_if_id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .clk_stall      (clk_stall),
        .branch_kill    (branch_kill),
        .jump_kill      (jump_kill),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; clk_stall = 1'b1; branch_kill = 1'b0; jump_kill = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        step(); step();
        chk("rst_addr",     imem_addr,                32'h0000_0000);
        chk("rst_pc",       if_id_pc,                 32'h0000_0000);
        chk("rst_instr",    if_id_instr,              32'h0000_0013);
        chk("rst_valid",    {31'b0, if_id_valid},     32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign},  32'h0);

        // Boot cycle: nothing captured
        reset = 1'b0;
        step();
        chk("boot_valid", {31'b0, if_id_valid}, 32'h0);
        chk("boot_instr", if_id_instr,          32'h0000_0013);
        chk("boot_addr",  imem_addr,            32'h0000_0000);
        step();
        chk("c2_pc",    if_id_pc,             32'h0000_0000);
        chk("c2_valid", {31'b0, if_id_valid}, 32'h1);
        chk("c2_instr", if_id_instr,          32'hDEAD_0000);
        step();
        chk("c3_pc",   if_id_pc,  32'h0000_0004);
        chk("c3_addr", imem_addr, 32'h0000_0008);
        step(); step();
        chk("pre_stall_addr", imem_addr, 32'h0000_0010);
        chk("pre_stall_pc",   if_id_pc,  32'h0000_000C);

        // Stall three cycles at pc=0x10
        clk_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr",  imem_addr,            32'h0000_0010);
            chk("stall_pc",    if_id_pc,             32'h0000_000C);
            chk("stall_instr", if_id_instr,          32'hDEAD_000C);
            chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
        end
        clk_stall = 1'b1;
        step();
        chk("unstall_pc",   if_id_pc,  32'h0000_0010);
        chk("unstall_addr", imem_addr, 32'h0000_0014);
        step(); step(); step();
        chk("pre_br_addr", imem_addr, 32'h0000_0020);

        // Branch beats jump and stall
        branch_kill = 1'b1; jump_kill = 1'b1; clk_stall = 1'b0;
        branch_target = 32'h0000_0100; jump_target = 32'h0000_0200;
        step();
        chk("br_addr",  imem_addr,            32'h0000_0100);
        chk("br_instr", if_id_instr,          32'h0000_0013);
        chk("br_valid", {31'b0, if_id_valid}, 32'h0);
        chk("br_pc",    if_id_pc,             32'h0000_0000);
        branch_kill = 1'b0; jump_kill = 1'b0; clk_stall = 1'b1;
        step();
        chk("br_next_pc",    if_id_pc,             32'h0000_0100);
        chk("br_next_valid", {31'b0, if_id_valid}, 32'h1);
        chk("br_next_instr", if_id_instr,          32'hDEAD_0100);

        // Jump beats stall
        jump_kill = 1'b1; clk_stall = 1'b0; jump_target = 32'h0000_0044;
        step();
        chk("jmp_addr",  imem_addr,            32'h0000_0044);
        chk("jmp_valid", {31'b0, if_id_valid}, 32'h0);
        chk("jmp_instr", if_id_instr,          32'h0000_0013);
        jump_kill = 1'b0; clk_stall = 1'b1;
        step();
        chk("jmp_next_pc",    if_id_pc,               32'h0000_0044);
        chk("jmp_next_valid", {31'b0, if_id_valid},   32'h1);
        chk("no_misalign",    {31'b0, fetch_misalign}, 32'h0);

        // Misaligned branch target
        branch_kill = 1'b1; branch_target = 32'h0000_0102;
        step();
        chk("mis_addr", imem_addr,               32'h0000_0100);
        chk("mis_flag", {31'b0, fetch_misalign}, 32'h1);
        branch_kill = 1'b0;
        jump_kill = 1'b1; jump_target = 32'h0000_0200;
        step();
        chk("mis_hold_addr", imem_addr,               32'h0000_0200);
        chk("mis_hold_flag", {31'b0, fetch_misalign}, 32'h1);

        // Reset mid-redirect, then kills ignored during BOOT
        reset = 1'b1;
        step();
        chk("rst2_addr",  imem_addr,               32'h0000_0000);
        chk("rst2_flag",  {31'b0, fetch_misalign}, 32'h0);
        chk("rst2_valid", {31'b0, if_id_valid},    32'h0);
        reset = 1'b0; branch_kill = 1'b1; jump_kill = 1'b1; clk_stall = 1'b0;
        branch_target = 32'h0000_0080; jump_target = 32'h0000_0090;
        step();
        chk("boot_kill_addr",  imem_addr,            32'h0000_0000);
        chk("boot_kill_valid", {31'b0, if_id_valid}, 32'h0);
        branch_kill = 1'b0; jump_kill = 1'b0; clk_stall = 1'b1;
        step();
        chk("run_after_boot_pc",    if_id_pc,             32'h0000_0000);
        chk("run_after_boot_valid", {31'b0, if_id_valid}, 32'h1);

        // Wrap-around at top of address space
        jump_kill = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
        jump_kill = 1'b0;
        step();
        chk("wrap_pc",    if_id_pc,                32'hFFFF_FFFC);
        chk("wrap_instr", if_id_instr,             32'h2152_FFFC);
        chk("wrap_addr",  imem_addr,               32'h0000_0000);
        chk("wrap_flag",  {31'b0, fetch_misalign}, 32'h0);
        step();
        chk("wrap_next_pc", if_id_pc, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core. It holds the PC, drives the instruction-memory address, and captures the fetched instruction into IF/ID. It consumes the hazard unit's clk_stall, branch_kill and jump_kill outputs to hold, redirect and flush the front end. A two-state boot sequencer guarantees a clean first fetch after reset.

Parameters:
XLEN, 32, PC/instruction/target width
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
clk_stall  in  1  from hazard unit; ACTIVE-LOW: 0 = load-use stall, 1 = advance
branch_kill  in  1  taken branch resolved in EX/MEM; redirect and flush
jump_kill  in  1  JAL/JALR in ID/EX; redirect and flush
branch_target  in  XLEN  redirect PC for branch_kill
jump_target  in  XLEN  redirect PC for jump_kill
imem_addr  out  XLEN  instruction-memory address; equals current PC (combinational from PC reg)
imem_rdata  in  32  instruction at imem_addr; combinational read, same cycle
if_id_pc  out  XLEN  PC of instruction held in IF/ID
if_id_instr  out  32  instruction held in IF/ID
if_id_valid  out  1  1 = IF/ID holds a real fetched instruction
fetch_misalign  out  1  sticky; set when any taken redirect target has bits [1:0] != 0

Behaviour:
- Reset (reset=1 at edge, overrides everything): pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; fetch_misalign=0; state=BOOT.
- State BOOT: lasts exactly one cycle after reset deasserts. PC and IF/ID hold; all kill/stall inputs ignored. Next state RUN.
- State RUN: per edge, strict priority:
  1. branch_kill=1: pc <= {branch_target[XLEN-1:2],2'b00}; if_id_instr <= NOP_INSTR; if_id_valid <= 0; if_id_pc <= 0. Overrides jump_kill and clk_stall.
  2. jump_kill=1: same as 1 using jump_target. Overrides clk_stall.
  3. clk_stall=0: pc, if_id_pc, if_id_instr, if_id_valid all hold.
  4. Otherwise: if_id_pc <= pc; if_id_instr <= imem_rdata; if_id_valid <= 1; pc <= pc+4.
- fetch_misalign: set at the edge where case 1 or 2 is taken with the selected target[1:0] != 0. Held until reset. Target is still force-aligned.
- PC arithmetic is modulo 2^XLEN. pc=32'hFFFFFFFC advancing gives 0, no flag.
- Latency: an instruction at address A appears in IF/ID one edge after PC=A with no stall/kill. After a redirect edge, the target instruction appears in IF/ID on the following edge, so each kill costs exactly one IF/ID bubble from this block.
- Reset mid-stall or mid-redirect: reset wins; the sequence restarts at BOOT.
- No RUN-state exit other than reset.

Test Plan:
- Reset/boot: hold reset 2 cycles, release, imem returns addr-based pattern -> cycle 1 if_id_valid=0, instr=0x00000013; cycle 2 if_id_pc=0, valid=1; cycle 3 if_id_pc=4; imem_addr=8.
- Stall: in RUN at pc=0x10, drive clk_stall=0 for 3 cycles -> imem_addr stays 0x10, IF/ID unchanged; on release, if_id_pc=0x10 next edge.
- Branch kill priority: at pc=0x20, assert branch_kill=1, jump_kill=1, clk_stall=0, branch_target=0x100, jump_target=0x200 -> pc=0x100, if_id_instr=0x00000013, valid=0; next edge if_id_pc=0x100, valid=1.
- Jump over stall: jump_kill=1, clk_stall=0, jump_target=0x44 -> pc=0x44, IF/ID flushed; kills ignored during BOOT (assert in BOOT cycle -> pc stays RESET_PC).
- Misalign: branch_kill with target=0x102 -> pc=0x100, fetch_misalign=1; stays 1 across later aligned redirects until reset.
- Wrap: redirect to 0xFFFFFFFC, advance -> if_id_pc=0xFFFFFFFC, then imem_addr=0x00000000, fetch_misalign=0.
